// File: rtl/soc_system_pio_key_in.sv
// soc_system_pio_key_in
//   Avalon-MM slave input PIO for board push-keys and switches on the HPS
//   lightweight bridge. It is the read-side partner of the LED output PIO.
//   Each asynchronous input passes through a 2-flop synchroniser and then a
//   per-bit debouncer. Software sees the debounced level, a per-bit edge
//   capture register and an interrupt mask. The block drives a level IRQ.
//
// Ports
//   clk, reset_n   system clock; asynchronous active-low reset
//   in_port        WIDTH asynchronous external inputs
//   address        word address:
//                    0 = data (RO)
//                    1 = reserved (reads 0)
//                    2 = irqmask (RW)
//                    3 = edgecapture (write 1 to clear)
//   chipselect     slave select
//   write_n        active-low write strobe, qualified by chipselect
//   writedata      write data; only bits [WIDTH-1:0] are used
//   readdata       zero-wait-state read data; unused upper bits read 0
//   irq            level interrupt, |(edgecapture & irqmask)
//
// Bus handshake
//   There is no wait-request. A write takes effect on the clk edge where
//   chipselect=1 and write_n=0. A read is purely combinational from address
//   and has no side effects.
module soc_system_pio_key_in #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic             wr_mask;
  logic             wr_ec;

  // The synchroniser resets to the idle level. This keeps an idle key from
  // looking like a press right after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      logic [WIDTH-1:0] stable_r;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stable_r <= IDLE_LEVEL;
        else          stable_r <= sync2;
      end
      assign stable = stable_r;
    end else begin : g_debounce
      localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt;
        logic          stable_bit;
        // The count runs only while the input disagrees with the accepted
        // level. Any agreeing sample, such as a bounce back, restarts it.
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt        <= '0;
            stable_bit <= IDLE_LEVEL[i];
          end else if (sync2[i] == stable_bit) begin
            cnt <= '0;
          end else if (cnt == LAST) begin
            cnt        <= '0;
            stable_bit <= sync2[i];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        assign stable[i] = stable_bit;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stable_d <= IDLE_LEVEL;
    else          stable_d <= stable;
  end

  always_comb begin
    case (EDGE_TYPE)
      0:       ev = stable & ~stable_d;
      1:       ev = ~stable & stable_d;
      default: ev = stable ^ stable_d;
    endcase
  end

  assign wr_mask = chipselect & ~write_n & (address == 2'd2);
  assign wr_ec   = chipselect & ~write_n & (address == 2'd3);
  assign clr     = wr_ec ? writedata[WIDTH-1:0] : '0;

  // A new event wins over a clear in the same cycle, so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_mask) irqmask <= writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clr) | ev;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable;
      2'd2:    readdata[WIDTH-1:0] = irqmask;
      2'd3:    readdata[WIDTH-1:0] = edgecapture;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_soc_system_pio_key_in.sv
module tb_soc_system_pio_key_in;

  logic        clk;
  logic        reset_n;
  logic [3:0]  in_port;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int total;
  int bad;

  soc_system_pio_key_in #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4),
    .EDGE_TYPE(1),
    .IDLE_LEVEL(4'hF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] v);
    @(negedge clk);
    in_port = v;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    #1;
    check(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    in_port    = 4'hF;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // 1: reset values, then idle inputs held
    #12;
    rd("rst_data", 2'd0, 32'hF);
    rd("rst_mask", 2'd2, 32'h0);
    rd("rst_ec",   2'd3, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ticks(1);
      check("idle_irq", {31'd0, irq}, 32'd0);
    end
    rd("idle_data", 2'd0, 32'hF);
    rd("idle_ec",   2'd3, 32'h0);

    // 2: single press on bit0, latency to data, edgecapture and irq
    bus_write(2'd2, 32'h1);
    rd("mask_rb", 2'd2, 32'h1);
    set_in(4'hE);
    ticks(1);                       // edge t
    ticks(4);                       // edge t+4
    rd("p_data_t4", 2'd0, 32'hF);
    ticks(1);                       // edge t+5
    rd("p_data_t5", 2'd0, 32'hE);
    rd("p_ec_t5",   2'd3, 32'h0);
    check("p_irq_t5", {31'd0, irq}, 32'd0);
    ticks(1);                       // edge t+6
    rd("p_ec_t6",   2'd3, 32'h1);
    check("p_irq_t6", {31'd0, irq}, 32'd1);

    // 3: bounce filtered, one capture after final settle
    bus_write(2'd3, 32'h1);
    rd("clr_ec", 2'd3, 32'h0);
    set_in(4'hF);
    ticks(10);
    rd("rel_data", 2'd0, 32'hF);
    rd("rel_ec",   2'd3, 32'h0);   // rising edge is not captured
    set_in(4'hE); ticks(1);
    set_in(4'hF); ticks(1);
    set_in(4'hE); ticks(1);
    set_in(4'hF); ticks(1);
    rd("b_data", 2'd0, 32'hF);
    rd("b_ec",   2'd3, 32'h0);
    set_in(4'hE);
    ticks(1);                       // edge t
    ticks(4);
    rd("b_data_t4", 2'd0, 32'hF);
    rd("b_ec_t4",   2'd3, 32'h0);
    ticks(1);
    rd("b_data_t5", 2'd0, 32'hE);
    rd("b_ec_t5",   2'd3, 32'h0);
    ticks(1);
    rd("b_ec_t6",   2'd3, 32'h1);

    // 4: set and clear in the same cycle leave the bit set
    set_in(4'hF);
    ticks(10);
    rd("s4_ec_hold", 2'd3, 32'h1);
    set_in(4'hE);
    ticks(1);                       // edge t
    ticks(4);                       // edge t+4
    @(posedge clk);                 // edge t+5, stable changes here
    bus_write(2'd3, 32'h1);         // sampled at edge t+6 together with ev
    rd("s4_ec_race", 2'd3, 32'h1);
    check("s4_irq_race", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h1);
    rd("s4_ec_clr", 2'd3, 32'h0);
    check("s4_irq_clr", {31'd0, irq}, 32'd0);

    // 5: masking and ignored writes
    set_in(4'hF);
    ticks(10);
    set_in(4'hC);
    ticks(10);
    rd("s5_ec", 2'd3, 32'h3);
    bus_write(2'd2, 32'h2);
    check("s5_irq_m2", {31'd0, irq}, 32'd1);
    bus_write(2'd2, 32'h0);
    check("s5_irq_m0", {31'd0, irq}, 32'd0);
    rd("s5_ec_kept", 2'd3, 32'h3);
    bus_write(2'd0, 32'hFFFF);
    rd("s5_data_ro", 2'd0, 32'hC);
    bus_write(2'd1, 32'hFFFF);
    rd("s5_rsvd", 2'd1, 32'h0);

    // 6: reset during a press in progress
    set_in(4'hF);
    ticks(10);
    bus_write(2'd3, 32'h3);
    bus_write(2'd2, 32'h2);
    rd("s6_ec_pre", 2'd3, 32'h0);
    set_in(4'hD);
    ticks(2);
    @(negedge clk);
    reset_n = 1'b0;
    in_port = 4'hF;
    #1;
    rd("s6_rst_data", 2'd0, 32'hF);
    rd("s6_rst_mask", 2'd2, 32'h0);
    rd("s6_rst_ec",   2'd3, 32'h0);
    check("s6_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ticks(20);
    rd("s6_post_data", 2'd0, 32'hF);
    rd("s6_post_ec",   2'd3, 32'h0);
    check("s6_post_irq", {31'd0, irq}, 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
